// File: rtl/reg_port_ctrl_if.sv
// Bundle of decode, execute and register-file port signals seen by reg_port_ctrl.
// master is the controller side; slave is the surrounding datapath.
interface reg_port_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rs;
  logic [ADDR_W-1:0] req_rt;
  logic [ADDR_W-1:0] req_rd;
  logic              req_wb;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              done;
  logic [ADDR_W-1:0] dir_a;
  logic [ADDR_W-1:0] dir_b;
  logic [ADDR_W-1:0] dir_wra;
  logic [DATA_W-1:0] di;
  logic              reg_rd;
  logic              reg_wr;
  logic [DATA_W-1:0] doa;
  logic [DATA_W-1:0] dob;

  modport master (
    input  req_valid, req_rs, req_rt, req_rd, req_wb, op_ready, res_valid, res_data, doa, dob,
    output req_ready, op_valid, op_a, op_b, done, dir_a, dir_b, dir_wra, di, reg_rd, reg_wr
  );

  modport slave (
    output req_valid, req_rs, req_rt, req_rd, req_wb, op_ready, res_valid, res_data, doa, dob,
    input  req_ready, op_valid, op_a, op_b, done, dir_a, dir_b, dir_wra, di, reg_rd, reg_wr
  );
endinterface

// File: rtl/reg_port_ctrl.sv
// Register-file port sequencer: read both operands, hand them to execute,
// optionally wait for the result and write it back. All outputs are registered.
module reg_port_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter bit ZERO_REG_WP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_port_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, OPER, WAIT_RES, WRITE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_q, rd_nx;
  logic              wb_q, wb_nx;

  logic              req_ready_nx, op_valid_nx, done_nx, reg_rd_nx, reg_wr_nx;
  logic [ADDR_W-1:0] dir_a_nx, dir_b_nx, dir_wra_nx;
  logic [DATA_W-1:0] op_a_nx, op_b_nx, di_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_q          <= '0;
      wb_q          <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.op_valid  <= 1'b0;
      bus.done      <= 1'b0;
      bus.reg_rd    <= 1'b0;
      bus.reg_wr    <= 1'b0;
      bus.dir_a     <= '0;
      bus.dir_b     <= '0;
      bus.dir_wra   <= '0;
      bus.op_a      <= '0;
      bus.op_b      <= '0;
      bus.di        <= '0;
    end else begin
      state         <= state_nx;
      rd_q          <= rd_nx;
      wb_q          <= wb_nx;
      bus.req_ready <= req_ready_nx;
      bus.op_valid  <= op_valid_nx;
      bus.done      <= done_nx;
      bus.reg_rd    <= reg_rd_nx;
      bus.reg_wr    <= reg_wr_nx;
      bus.dir_a     <= dir_a_nx;
      bus.dir_b     <= dir_b_nx;
      bus.dir_wra   <= dir_wra_nx;
      bus.op_a      <= op_a_nx;
      bus.op_b      <= op_b_nx;
      bus.di        <= di_nx;
    end
  end

  // Outputs are computed for the next state so they appear registered in it.
  always_comb begin
    state_nx    = state;
    rd_nx       = rd_q;
    wb_nx       = wb_q;
    dir_a_nx    = bus.dir_a;
    dir_b_nx    = bus.dir_b;
    dir_wra_nx  = bus.dir_wra;
    op_a_nx     = bus.op_a;
    op_b_nx     = bus.op_b;
    di_nx       = bus.di;
    op_valid_nx = 1'b0;
    done_nx     = 1'b0;
    reg_rd_nx   = 1'b0;
    reg_wr_nx   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_nx  = READ;
          rd_nx     = bus.req_rd;
          wb_nx     = bus.req_wb;
          dir_a_nx  = bus.req_rs;
          dir_b_nx  = bus.req_rt;
          reg_rd_nx = 1'b1;
        end
      end
      READ: begin
        // The register file has driven doa/dob since the negedge of this cycle.
        op_a_nx     = bus.doa;
        op_b_nx     = bus.dob;
        op_valid_nx = 1'b1;
        state_nx    = OPER;
      end
      OPER: begin
        if (bus.op_ready) begin
          if (wb_q) begin
            state_nx = WAIT_RES;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end else begin
          op_valid_nx = 1'b1;
        end
      end
      WAIT_RES: begin
        if (bus.res_valid) begin
          di_nx      = bus.res_data;
          dir_wra_nx = rd_q;
          reg_wr_nx  = !(ZERO_REG_WP && (rd_q == '0));
          state_nx   = WRITE;
        end
      end
      WRITE: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    req_ready_nx = (state_nx == IDLE);
  end

endmodule

// File: tb/tb_reg_port_ctrl.sv
// Bench for reg_port_ctrl: register-file model on the port, directed table,
// hand-written reset/abuse sequences and random requests against a transaction model.
module tb_reg_port_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_port_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  reg_port_ctrl #(.ADDR_W(5), .DATA_W(32), .ZERO_REG_WP(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Register file attached to the port: samples and writes on the negedge.
  logic [31:0] rf [32];
  // Architectural expectation of register contents, updated per retired request.
  logic [31:0] mdl [32];

  always @(negedge clk) begin
    if (bus.reg_wr) rf[bus.dir_wra] = bus.di;
    if (bus.reg_rd) begin
      bus.doa = rf[bus.dir_a];
      bus.dob = rf[bus.dir_b];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void mdl_commit(input logic [4:0] rd, input logic wb, input logic [31:0] d);
    if (wb && rd != 5'd0) mdl[rd] = d;
  endfunction

  // One complete request; returns in the cycle where done is high.
  task automatic do_req(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic wb, input int op_dly, input int res_dly,
                        input logic [31:0] res, input logic [31:0] exp_a,
                        input logic [31:0] exp_b, input logic exp_wr);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
    bus.req_rd    = rd;
    bus.req_wb    = wb;
    bus.op_ready  = (op_dly == 0);
    step();
    bus.req_valid = 1'b0;
    bus.req_rs    = 5'($urandom);
    bus.req_rt    = 5'($urandom);
    bus.req_rd    = 5'($urandom);
    bus.req_wb    = 1'($urandom);
    chk("read_strobe", 32'(bus.reg_rd), 32'd1);
    chk("dir_a", 32'(bus.dir_a), 32'(rs));
    chk("dir_b", 32'(bus.dir_b), 32'(rt));
    chk("wr_in_read", 32'(bus.reg_wr), 32'd0);
    chk("done_in_read", 32'(bus.done), 32'd0);
    chk("busy_ready", 32'(bus.req_ready), 32'd0);
    chk("early_op_valid", 32'(bus.op_valid), 32'd0);
    step();
    chk("op_valid", 32'(bus.op_valid), 32'd1);
    chk("op_a", bus.op_a, exp_a);
    chk("op_b", bus.op_b, exp_b);
    chk("read_one_cycle", 32'(bus.reg_rd), 32'd0);
    if (op_dly > 0) bus.res_valid = 1'b1;
    for (int k = 1; k <= op_dly; k++) begin
      step();
      bus.res_valid = 1'b0;
      chk("stall_op_valid", 32'(bus.op_valid), 32'd1);
      chk("stall_op_a", bus.op_a, exp_a);
      chk("stall_op_b", bus.op_b, exp_b);
      chk("stall_done", 32'(bus.done), 32'd0);
      bus.op_ready = (k == op_dly);
    end
    step();
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    chk("op_valid_drop", 32'(bus.op_valid), 32'd0);
    if (!wb) begin
      chk("rdonly_done", 32'(bus.done), 32'd1);
      chk("rdonly_ready", 32'(bus.req_ready), 32'd1);
      chk("rdonly_no_wr", 32'(bus.reg_wr), 32'd0);
    end else begin
      chk("wait_done", 32'(bus.done), 32'd0);
      chk("wait_ready", 32'(bus.req_ready), 32'd0);
      for (int k = 0; k < res_dly; k++) begin
        step();
        chk("wait_no_wr", 32'(bus.reg_wr), 32'd0);
        chk("wait_no_done", 32'(bus.done), 32'd0);
      end
      bus.res_valid = 1'b1;
      bus.res_data  = res;
      step();
      bus.res_valid = 1'b0;
      bus.res_data  = $urandom;
      chk("write_strobe", 32'(bus.reg_wr), 32'(exp_wr));
      chk("dir_wra", 32'(bus.dir_wra), 32'(rd));
      chk("di", bus.di, res);
      chk("write_no_rd", 32'(bus.reg_rd), 32'd0);
      chk("write_no_done", 32'(bus.done), 32'd0);
      step();
      chk("wb_done", 32'(bus.done), 32'd1);
      chk("wb_ready", 32'(bus.req_ready), 32'd1);
      chk("wb_wr_drop", 32'(bus.reg_wr), 32'd0);
    end
  endtask

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        wb;
    int          op_dly, res_dly;
    logic [31:0] res, exp_a, exp_b;
    logic        exp_wr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [4:0]  rs, rt, rd;
    logic        wb, exp_wr;
    logic [31:0] d;
    int          od, rdl;

    for (int i = 0; i < 32; i++) begin
      rf[i]  = 32'h100 + i;
      mdl[i] = 32'h100 + i;
    end
    rf[0] = 32'd0;  mdl[0] = 32'd0;
    rf[4] = 32'd18; mdl[4] = 32'd18;
    rf[5] = 32'd7;  mdl[5] = 32'd7;

    tbl[0] = '{5'd4, 5'd5, 5'd0, 1'b0, 0, 0, 32'h0,        32'd18,       32'd7,        1'b0};
    tbl[1] = '{5'd4, 5'd5, 5'd6, 1'b1, 3, 1, 32'd25,       32'd18,       32'd7,        1'b1};
    tbl[2] = '{5'd6, 5'd4, 5'd0, 1'b0, 0, 0, 32'h0,        32'd25,       32'd18,       1'b0};
    tbl[3] = '{5'd1, 5'd2, 5'd0, 1'b1, 0, 0, 32'hDEADBEEF, 32'h101,      32'h102,      1'b0};
    tbl[4] = '{5'd0, 5'd6, 5'd3, 1'b0, 1, 0, 32'h0,        32'd0,        32'd25,       1'b0};
    tbl[5] = '{5'd7, 5'd0, 5'd7, 1'b1, 1, 2, 32'h12345678, 32'h107,      32'd0,        1'b1};
    tbl[6] = '{5'd7, 5'd7, 5'd0, 1'b0, 2, 0, 32'h0,        32'h12345678, 32'h12345678, 1'b0};

    // Reset with random inputs on every slave-driven signal
    bus.req_valid = 1'b1;
    bus.req_rs    = 5'($urandom);
    bus.req_rt    = 5'($urandom);
    bus.req_rd    = 5'($urandom);
    bus.req_wb    = 1'b1;
    bus.op_ready  = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_data  = $urandom;
    bus.doa       = $urandom;
    bus.dob       = $urandom;
    repeat (3) step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_reg_rd", 32'(bus.reg_rd), 32'd0);
    chk("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
    chk("rst_op_a", bus.op_a, 32'd0);
    chk("rst_op_b", bus.op_b, 32'd0);
    chk("rst_di", bus.di, 32'd0);
    chk("rst_dirs", 32'({bus.dir_a, bus.dir_b, bus.dir_wra}), 32'd0);
    bus.req_valid = 1'b0;
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_quiet", 32'({bus.reg_rd, bus.reg_wr, bus.done, bus.op_valid}), 32'd0);
    end

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_req(tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].wb, tbl[i].op_dly, tbl[i].res_dly,
             tbl[i].res, tbl[i].exp_a, tbl[i].exp_b, tbl[i].exp_wr);
      mdl_commit(tbl[i].rd, tbl[i].wb, tbl[i].res);
    end
    step();

    // Reset while waiting for the result, then a late res_valid
    bus.req_valid = 1'b1; bus.req_rs = 5'd1; bus.req_rt = 5'd2; bus.req_rd = 5'd9; bus.req_wb = 1'b1;
    step();
    bus.req_valid = 1'b0; bus.op_ready = 1'b1;
    step();
    step();
    bus.op_ready = 1'b0;
    chk("wr_wait_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wait_quiet", 32'({bus.reg_wr, bus.done, bus.op_valid}), 32'd0);
    step();
    rst_n = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_data  = 32'hCAFE0009;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("late_res_no_wr", 32'(bus.reg_wr), 32'd0);
      chk("late_res_no_done", 32'(bus.done), 32'd0);
      chk("late_res_ready", 32'(bus.req_ready), 32'd1);
    end
    bus.res_valid = 1'b0;

    // Reset in the WRITE cycle drops reg_wr at once
    bus.req_valid = 1'b1; bus.req_rs = 5'd3; bus.req_rt = 5'd4; bus.req_rd = 5'd10; bus.req_wb = 1'b1;
    step();
    bus.req_valid = 1'b0; bus.op_ready = 1'b1;
    step();
    step();
    bus.op_ready = 1'b0; bus.res_valid = 1'b1; bus.res_data = 32'hBAD0000A;
    step();
    bus.res_valid = 1'b0;
    chk("pre_rst_wr", 32'(bus.reg_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_wr", 32'(bus.reg_wr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_write_no_done", 32'(bus.done), 32'd0);
    do_req(5'd9, 5'd10, 5'd0, 1'b0, 0, 0, 32'd0, mdl[9], mdl[10], 1'b0);
    step();

    // req_valid held high while busy; accepted again only once ready
    bus.req_valid = 1'b1; bus.req_rs = 5'd4; bus.req_rt = 5'd5; bus.req_rd = 5'd0; bus.req_wb = 1'b0;
    bus.op_ready = 1'b0;
    step();
    chk("hold_rd1", 32'(bus.reg_rd), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_no_rd", 32'(bus.reg_rd), 32'd0);
      chk("hold_not_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.op_ready = 1'b1;
    step();
    chk("hold_done", 32'(bus.done), 32'd1);
    chk("hold_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk("hold_reaccept", 32'(bus.reg_rd), 32'd1);
    chk("hold_done_once", 32'(bus.done), 32'd0);
    step();
    chk("hold_op_a", bus.op_a, mdl[4]);
    step();
    bus.op_ready = 1'b0;
    chk("hold_done2", 32'(bus.done), 32'd1);
    step();

    // Random requests against the transaction model
    for (int n = 0; n < 60; n++) begin
      rs  = 5'($urandom_range(0, 31));
      rt  = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      if (n % 8 == 0) rd = 5'd0;
      wb  = 1'($urandom_range(0, 1));
      od  = $urandom_range(0, 2);
      rdl = $urandom_range(0, 2);
      d   = $urandom;
      exp_wr = wb && (rd != 5'd0);
      do_req(rs, rt, rd, wb, od, rdl, d, mdl[rs], mdl[rt], exp_wr);
      mdl_commit(rd, wb, d);
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
